// File: rtl/lcd_rect_fill_if.sv
// ---------------------------------------------------------------------------
// lcd_rect_fill_if
// Packet stream from the window-fill generator into the SPI transmit FIFO.
//   valid : a packet is presented on data (driven by the master)
//   ready : the sink accepts the packet (driven by the slave)
//   data  : packet {dc, byte}; dc = 0 for command, 1 for data
// A packet moves on a rising clock edge with valid && ready.
// ---------------------------------------------------------------------------
interface lcd_rect_fill_if #(
    parameter int PACKET_WIDTH = 9
);
    logic                    valid;
    logic                    ready;
    logic [PACKET_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/lcd_rect_fill.sv
// ---------------------------------------------------------------------------
// lcd_rect_fill
// ST7789V3 window-fill packet generator. A start pulse latches a rectangle
// and an RGB888 colour, then the block streams CASET, RASET, RAMWR and the
// pixel bytes that fill the rectangle, honouring sink backpressure.
//   clk            : sole clock
//   rst            : asynchronous, active-low reset
//   en             : start pulse, sampled in IDLE only
//   x0/x1, y0/y1   : inclusive column / row bounds
//   color          : fill colour {R,G,B}
//   tx             : packet stream (valid/ready/data), master side
//   busy           : a sequence is in progress
//   done           : one-cycle pulse after the last packet is accepted
//   err            : one-cycle pulse when a start is refused (x1<x0 or y1<y0)
// ---------------------------------------------------------------------------
module lcd_rect_fill #(
    parameter int WORD_WIDTH   = 8,
    parameter int PACKET_WIDTH = WORD_WIDTH + 1,
    parameter int X_WIDTH      = 9,
    parameter int Y_WIDTH      = 9,
    parameter int X_OFFSET     = 0,
    parameter int Y_OFFSET     = 0,
    parameter int PIXEL_FMT    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [X_WIDTH-1:0] x0,
    input  logic [X_WIDTH-1:0] x1,
    input  logic [Y_WIDTH-1:0] y0,
    input  logic [Y_WIDTH-1:0] y1,
    input  logic [23:0]        color,
    lcd_rect_fill_if.master    tx,
    output logic               busy,
    output logic               done,
    output logic               err
);
    // Pixel counter must hold the full-screen count 2^(X_WIDTH+Y_WIDTH).
    localparam int CW = X_WIDTH + Y_WIDTH + 1;

    localparam logic [1:0]       LAST_PHASE = (PIXEL_FMT == 0) ? 2'd1 : 2'd2;
    localparam logic [X_WIDTH:0] X_OFF      = (X_WIDTH + 1)'(X_OFFSET);
    localparam logic [Y_WIDTH:0] Y_OFF      = (Y_WIDTH + 1)'(Y_OFFSET);
    localparam logic [X_WIDTH:0] X_ONE      = 1;
    localparam logic [Y_WIDTH:0] Y_ONE      = 1;
    localparam logic [CW-1:0]    CNT_ONE    = 1;

    typedef enum logic [2:0] {
        IDLE, CASET_CMD, CASET_ARG, RASET_CMD, RASET_ARG, RAMWR_CMD, PIXELS
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              arg_q, arg_d;       // argument byte index 0..3
    logic [1:0]              phase_q, phase_d;   // byte within current pixel
    logic [CW-1:0]           cnt_q, cnt_d;       // pixels still to send
    logic [X_WIDTH-1:0]      x0_q, x0_d, x1_q, x1_d;
    logic [Y_WIDTH-1:0]      y0_q, y0_d, y1_q, y1_d;
    logic [23:0]             color_q, color_d;
    logic                    valid_q, valid_d;
    logic [PACKET_WIDTH-1:0] data_q, data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    xfer;
    logic [X_WIDTH:0]        xs_n, xe_n, w_len;
    logic [Y_WIDTH:0]        ys_n, ye_n, h_len;
    logic [15:0]             xs, xe, ys, ye, start_c, end_c;
    logic [CW-1:0]           n_pix;
    logic [WORD_WIDTH-1:0]   arg_byte, pix_byte;
    logic                    unused_color;

    assign xfer = valid_q && tx.ready;

    // Panel coordinates wrap at X_WIDTH+1 / Y_WIDTH+1 bits before widening.
    assign xs_n = {1'b0, x0_q} + X_OFF;
    assign xe_n = {1'b0, x1_q} + X_OFF;
    assign ys_n = {1'b0, y0_q} + Y_OFF;
    assign ye_n = {1'b0, y1_q} + Y_OFF;
    assign xs   = 16'(xs_n);
    assign xe   = 16'(xe_n);
    assign ys   = 16'(ys_n);
    assign ye   = 16'(ye_n);

    assign w_len = {1'b0, x1_q} - {1'b0, x0_q} + X_ONE;
    assign h_len = {1'b0, y1_q} - {1'b0, y0_q} + Y_ONE;
    assign n_pix = CW'(w_len) * CW'(h_len);

    // Low colour bits are dropped by both pixel packings.
    assign unused_color = ^color_q;

    // Control: sequencing, counters and window latch.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path infers a latch.
        state_d = state_q;
        arg_d   = arg_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        color_d = color_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    if (x1 >= x0 && y1 >= y0) begin
                        x0_d    = x0;
                        x1_d    = x1;
                        y0_d    = y0;
                        y1_d    = y1;
                        color_d = color;
                        busy_d  = 1'b1;
                        valid_d = 1'b1;
                        state_d = CASET_CMD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CASET_CMD: if (xfer) begin
                state_d = CASET_ARG;
                arg_d   = '0;
            end
            CASET_ARG: if (xfer) begin
                if (arg_q == 2'd3) state_d = RASET_CMD;
                else               arg_d   = arg_q + 2'd1;
            end
            RASET_CMD: if (xfer) begin
                state_d = RASET_ARG;
                arg_d   = '0;
            end
            RASET_ARG: if (xfer) begin
                if (arg_q == 2'd3) state_d = RAMWR_CMD;
                else               arg_d   = arg_q + 2'd1;
            end
            RAMWR_CMD: if (xfer) begin
                state_d = PIXELS;
                phase_d = '0;
                cnt_d   = n_pix;
            end
            PIXELS: if (xfer) begin
                if (phase_q == LAST_PHASE) begin
                    phase_d = '0;
                    cnt_d   = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Packet selection: data_q always shows the packet for the state being
    // entered, so a transfer is followed directly by the next packet.
    always_comb begin
        start_c = (state_d == CASET_ARG) ? xs : ys;
        end_c   = (state_d == CASET_ARG) ? xe : ye;

        case (arg_d)
            2'd0:    arg_byte = start_c[15:8];
            2'd1:    arg_byte = start_c[7:0];
            2'd2:    arg_byte = end_c[15:8];
            default: arg_byte = end_c[7:0];
        endcase

        if (PIXEL_FMT == 0) begin
            case (phase_d)
                2'd0:    pix_byte = {color_q[23:19], color_q[15:13]};
                default: pix_byte = {color_q[12:10], color_q[7:3]};
            endcase
        end else begin
            case (phase_d)
                2'd0:    pix_byte = {color_q[23:18], 2'b00};
                2'd1:    pix_byte = {color_q[15:10], 2'b00};
                default: pix_byte = {color_q[7:2], 2'b00};
            endcase
        end

        data_d = data_q;
        if (state_d != IDLE && (xfer || state_q == IDLE)) begin
            case (state_d)
                CASET_CMD:            data_d = {1'b0, 8'h2A};
                RASET_CMD:            data_d = {1'b0, 8'h2B};
                RAMWR_CMD:            data_d = {1'b0, 8'h2C};
                CASET_ARG, RASET_ARG: data_d = {1'b1, arg_byte};
                PIXELS:               data_d = {1'b1, pix_byte};
                default:              data_d = data_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            arg_q   <= '0;
            phase_q <= '0;
            cnt_q   <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every flop sampling pre-edge values.
            state_q <= state_d;
            arg_q   <= arg_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            color_q <= color_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign tx.valid = valid_q;
    assign tx.data  = data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
endmodule
